// File: rtl/stopwatch_ctrl_pkg.sv
// Shared stopwatch definitions: FSM state codes, counter enable levels and default timing constants.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        STAT_IDLE  = 2'b00,
        STAT_RUN   = 2'b01,
        STAT_PAUSE = 2'b10,
        STAT_LAP   = 2'b11
    } sw_state_e;

    localparam logic CNT_EN  = 1'b1;
    localparam logic CNT_DIS = 1'b0;

    localparam int DEFAULT_DEBOUNCE_CYCLES   = 20000;
    localparam int DEFAULT_LONG_PRESS_CYCLES = 2000000;

    // The time counter advances in both running states, frozen display or not.
    function automatic logic is_counting(input sw_state_e s);
        return (s == STAT_RUN) || (s == STAT_LAP);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and counter/display controls of the stopwatch, bundled for board-side and controller-side use.
interface stopwatch_ctrl_if;

    logic       btn_start_raw;
    logic       btn_lap_raw;
    logic       count_enable;
    logic       count_clear;
    logic       disp_freeze;
    logic [1:0] state_o;

    modport master (
        output btn_start_raw, btn_lap_raw,
        input  count_enable, count_clear, disp_freeze, state_o
    );

    modport slave (
        input  btn_start_raw, btn_lap_raw,
        output count_enable, count_clear, disp_freeze, state_o
    );

endinterface

// File: rtl/stopwatch_ctrl_btn_conditioner.sv
// One push-button front end: 2-FF synchroniser, debounce, press one-pulse and optional long-press pulse.
module btn_conditioner
    import stopwatch_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
    parameter bit LONG_EN           = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press,
    output logic long_pulse
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1;
    logic            sync2;
    logic            level_d;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Any cycle where the synced input agrees with the level restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level  <= 1'b0;
            db_cnt <= '0;
        end else if (sync2 == level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            level  <= ~level;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

    generate
        if (LONG_EN) begin : g_long
            localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
            localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
            localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

            logic [HOLD_W-1:0] hold_cnt;

            // Saturating at HOLD_MAX is what limits a hold to a single long pulse.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_cnt   <= '0;
                    long_pulse <= 1'b0;
                end else begin
                    long_pulse <= level && (hold_cnt == HOLD_LAST);
                    if (!level) begin
                        hold_cnt <= '0;
                    end else if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            end
        end else begin : g_no_long
            assign long_pulse = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/stopwatch_ctrl.sv
// Two-button stopwatch controller: conditions START and LAP, runs the run/pause/lap/clear FSM
// and drives registered counter enable, clear and display-freeze controls.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input logic             clk,
    input logic             rst_n,
    stopwatch_ctrl_if.slave bus
);

    logic      start_press;
    logic      start_long_unused;
    logic      start_level_unused;
    logic      lap_press;
    logic      lap_long;
    logic      lap_level_unused;
    sw_state_e state;
    sw_state_e state_next;
    logic      clear_next;

    btn_conditioner #(
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
        .LONG_EN          (1'b0)
    ) u_start (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (bus.btn_start_raw),
        .level     (start_level_unused),
        .press     (start_press),
        .long_pulse(start_long_unused)
    );

    btn_conditioner #(
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
        .LONG_EN          (1'b1)
    ) u_lap (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (bus.btn_lap_raw),
        .level     (lap_level_unused),
        .press     (lap_press),
        .long_pulse(lap_long)
    );

    // Outputs are computed from the next state so they change on the same edge as state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= STAT_IDLE;
            bus.count_enable <= CNT_DIS;
            bus.disp_freeze  <= 1'b0;
            bus.count_clear  <= 1'b0;
        end else begin
            state            <= state_next;
            bus.count_enable <= is_counting(state_next) ? CNT_EN : CNT_DIS;
            bus.disp_freeze  <= (state_next == STAT_LAP);
            bus.count_clear  <= clear_next;
        end
    end

    assign bus.state_o = state;

    // Priority: long press, then START, then LAP; a LAP pulse alongside START is dropped.
    always_comb begin
        state_next = state;
        clear_next = 1'b0;
        if (lap_long) begin
            state_next = STAT_IDLE;
            clear_next = 1'b1;
        end else if (start_press) begin
            unique case (state)
                STAT_IDLE:  state_next = STAT_RUN;
                STAT_RUN:   state_next = STAT_PAUSE;
                STAT_PAUSE: state_next = STAT_RUN;
                STAT_LAP:   state_next = STAT_PAUSE;
            endcase
        end else if (lap_press) begin
            unique case (state)
                STAT_IDLE: begin
                    state_next = STAT_IDLE;
                    clear_next = 1'b1;
                end
                STAT_RUN:   state_next = STAT_LAP;
                STAT_PAUSE: begin
                    state_next = STAT_IDLE;
                    clear_next = 1'b1;
                end
                STAT_LAP:   state_next = STAT_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Stopwatch controller bench: directed scenarios plus random button traffic, checked every cycle
// against a history-window model of the button and state rules.
module tb_stopwatch_ctrl;

    localparam int DB     = 4;
    localparam int LP     = 20;
    localparam int HIST   = 32;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_PAUSE = 2;
    localparam int S_LAP  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES  (DB),
        .LONG_PRESS_CYCLES(LP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int clear_seen = 0;
    bit lap_seen   = 1'b0;

    // Model histories, bit 0 = value at the most recent edge.
    logic [HIST-1:0] rs_h, rl_h, ls_h, ll_h;
    logic ps_p, pl_p, lg_p;
    int   m_state;
    logic m_clear;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s @%0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic l, input int n);
        bus.btn_start_raw = s;
        bus.btn_lap_raw   = l;
        repeat (n) @(negedge clk);
    endtask

    task automatic modelReset();
        rs_h = '0; rl_h = '0; ls_h = '0; ll_h = '0;
        ps_p = 1'b0; pl_p = 1'b0; lg_p = 1'b0;
        m_state = S_IDLE;
        m_clear = 1'b0;
    endtask

    // Level flips once the last DB synced samples (raw delayed by two edges) all disagree with it.
    function automatic logic nextLevel(input logic cur, input logic [HIST-1:0] raw_h);
        logic all_diff;
        all_diff = 1'b1;
        for (int k = 2; k <= DB + 1; k++) if (raw_h[k] == cur) all_diff = 1'b0;
        return all_diff ? ~cur : cur;
    endfunction

    function automatic logic longFires(input logic [HIST-1:0] lv);
        for (int k = 1; k <= LP; k++) if (!lv[k]) return 1'b0;
        return !lv[LP+1];
    endfunction

    task automatic modelStep();
        rs_h = {rs_h[HIST-2:0], bus.btn_start_raw};
        rl_h = {rl_h[HIST-2:0], bus.btn_lap_raw};
        ls_h = {ls_h[HIST-2:0], nextLevel(ls_h[0], rs_h)};
        ll_h = {ll_h[HIST-2:0], nextLevel(ll_h[0], rl_h)};
        m_clear = 1'b0;
        if (lg_p) begin
            m_state = S_IDLE;
            m_clear = 1'b1;
        end else if (ps_p) begin
            m_state = (m_state == S_RUN || m_state == S_LAP) ? S_PAUSE : S_RUN;
        end else if (pl_p) begin
            if (m_state == S_RUN) m_state = S_LAP;
            else if (m_state == S_LAP) m_state = S_RUN;
            else begin
                m_state = S_IDLE;
                m_clear = 1'b1;
            end
        end
        ps_p = ls_h[1] & ~ls_h[2];
        pl_p = ll_h[1] & ~ll_h[2];
        lg_p = longFires(ll_h);
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) modelReset();
            else modelStep();
        end
    end

    initial begin
        @(negedge clk);
        forever begin
            @(negedge clk);
            checkOutput("model_en",    32'(bus.count_enable), 32'(m_state == S_RUN || m_state == S_LAP));
            checkOutput("model_frz",   32'(bus.disp_freeze),  32'(m_state == S_LAP));
            checkOutput("model_clr",   32'(bus.count_clear),  32'(m_clear));
            checkOutput("model_state", 32'(bus.state_o),      32'(m_state));
            if (bus.count_clear === 1'b1) clear_seen++;
            if (bus.state_o === 2'b11) lap_seen = 1'b1;
        end
    end

    task automatic pressStart();
        applyStimulus(1'b1, 1'b0, 8);
        applyStimulus(1'b0, 1'b0, 10);
    endtask

    task automatic pressLap();
        applyStimulus(1'b0, 1'b1, 8);
        applyStimulus(1'b0, 1'b0, 10);
    endtask

    initial begin
        int clr0;
        bus.btn_start_raw = 1'b0;
        bus.btn_lap_raw   = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_en",    32'(bus.count_enable), 0);
        checkOutput("reset_clr",   32'(bus.count_clear),  0);
        checkOutput("reset_frz",   32'(bus.disp_freeze),  0);
        checkOutput("reset_state", 32'(bus.state_o),      0);
        rst_n = 1'b1;
        @(negedge clk);

        // START press: enable appears exactly 7 edges after the raw rise is first sampled
        applyStimulus(1'b1, 1'b0, 7);
        checkOutput("start_early_en", 32'(bus.count_enable), 0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("start_en",    32'(bus.count_enable), 1);
        checkOutput("start_state", 32'(bus.state_o),      S_RUN);
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 12);

        for (int i = 0; i < 6; i++) applyStimulus(1'((i % 2) == 0), 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("bounce_state", 32'(bus.state_o), S_RUN);
        pressStart();
        checkOutput("pause_state", 32'(bus.state_o),      S_PAUSE);
        checkOutput("pause_en",    32'(bus.count_enable), 0);

        pressStart();
        pressLap();
        checkOutput("lap_state", 32'(bus.state_o),      S_LAP);
        checkOutput("lap_frz",   32'(bus.disp_freeze),  1);
        checkOutput("lap_en",    32'(bus.count_enable), 1);
        pressLap();
        checkOutput("unlap_state", 32'(bus.state_o),     S_RUN);
        checkOutput("unlap_frz",   32'(bus.disp_freeze), 0);
        pressLap();
        pressStart();
        checkOutput("lap_start_state", 32'(bus.state_o),      S_PAUSE);
        checkOutput("lap_start_en",    32'(bus.count_enable), 0);
        checkOutput("lap_start_frz",   32'(bus.disp_freeze),  0);

        clr0 = clear_seen;
        pressLap();
        checkOutput("clear_state", 32'(bus.state_o), S_IDLE);
        checkOutput("clear_count", 32'(clear_seen - clr0), 1);

        pressStart();
        lap_seen = 1'b0;
        clr0 = clear_seen;
        applyStimulus(1'b0, 1'b1, 30);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("long_saw_lap", 32'(lap_seen), 1);
        checkOutput("long_state",   32'(bus.state_o), S_IDLE);
        checkOutput("long_clears",  32'(clear_seen - clr0), 1);

        pressStart();
        lap_seen = 1'b0;
        clr0 = clear_seen;
        applyStimulus(1'b1, 1'b1, 8);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("simul_state",  32'(bus.state_o), S_PAUSE);
        checkOutput("simul_clears", 32'(clear_seen - clr0), 0);
        checkOutput("simul_no_lap", 32'(lap_seen), 0);

        pressStart();
        applyStimulus(1'b0, 1'b1, 16);
        checkOutput("midhold_state", 32'(bus.state_o), S_LAP);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_en",    32'(bus.count_enable), 0);
        checkOutput("midrst_frz",   32'(bus.disp_freeze),  0);
        checkOutput("midrst_state", 32'(bus.state_o),      0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clr0 = clear_seen;
        applyStimulus(1'b0, 1'b1, 15);
        checkOutput("held_state",  32'(bus.state_o), S_IDLE);
        checkOutput("held_clears", 32'(clear_seen - clr0), 1);
        applyStimulus(1'b0, 1'b0, 10);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 14) == 0) begin
                #2 rst_n = 1'b0;
                repeat (2) @(negedge clk);
                #2 rst_n = 1'b1;
                @(negedge clk);
            end else begin
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              int'($urandom_range(1, 30)));
            end
        end
        applyStimulus(1'b0, 1'b0, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
